operand_pair_serializer: RTL and testbench
==========================================

# operand_pair_serializer

Upstream feeder for the 16-bit 2-to-1 selection mux. Accepts a pair of 16-bit operands through a valid/ready handshake and holds them in two registers that drive the mux data inputs. It then steps the mux select so the pair leaves the mux output as two consecutive words under a second valid/ready handshake. A wrapping counter records completed pairs.

## Interface
- DATA_W, default `DATA_BITS (16): operand width; must equal the mux data width.
- CNT_W, default 8: width of the completed-pair counter.

- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer offers a pair.
- in_ready  output  1  serializer accepts the pair this cycle (combinational).
- in_data1  input  DATA_W  operand routed to mux input 1.
- in_data2  input  DATA_W  operand routed to mux input 2.
- in_order  input  1  0: in_data1 emitted first; 1: in_data2 first. Latched with the pair.
- Data_in1  output  DATA_W  registered; drives mux Data_in1.
- Data_in2  output  DATA_W  registered; drives mux Data_in2.
- sel  output  1  drives mux sel (0 selects Data_in1).
- out_valid  output  1  the mux output holds a valid word.
- out_ready  input  1  consumer takes the word this cycle.
- out_last  output  1  the current word is the second word of its pair.
- pair_cnt  output  CNT_W  count of completed pairs.

## Operation
- The block has three states:
  - IDLE: no pair held.
  - FIRST: the first word is being presented.
  - SECOND: the second word is being presented.
- in_ready = (state==IDLE) | (state==SECOND & out_ready).
- Accept = in_valid & in_ready. On accept:
  - Data_in1 <= in_data1, Data_in2 <= in_data2, the order bit <= in_order.
  - Next state is FIRST.
- FIRST:
  - out_valid=1, out_last=0, sel = order bit.
  - out_ready moves the block to SECOND; otherwise it stays in FIRST.
- SECOND:
  - out_valid=1, out_last=1, sel = ~order bit.
  - out_ready increments pair_cnt. Next state is FIRST if a new pair is accepted in the same cycle, otherwise IDLE.
  - Without out_ready the block holds in SECOND.
- IDLE: out_valid=0, out_last=0, sel=0. Data registers keep their last values.
- Data_in1, Data_in2, the order bit, sel and out_last are stable whenever out_valid=1 and out_ready=0.
- pair_cnt wraps from 2^CNT_W-1 to 0 with no flag.
- in_valid while in FIRST, or in SECOND without out_ready, is not accepted. The producer must hold in_valid and its data.
- Reset mid-pair drops the held pair. No partial output follows.

## Timing
- Reset values:
  - state IDLE
  - Data_in1=0, Data_in2=0, order bit=0
  - sel=0, out_valid=0, out_last=0, pair_cnt=0
  - in_ready=1 in the first cycle after reset
- Latency: a pair accepted at edge N gives its first word valid on the mux output in cycle N+1. The second word follows one cycle after the first handshake.
- Throughput: 1 word/cycle sustained with out_ready=1 and in_valid=1. Pairs run back-to-back with no bubble.
- in_ready depends combinationally on out_ready. All other outputs are registered or decoded from registered state only.
- rst has priority over every handshake in the same cycle.

## Structure
- `DATA_BITS comes from def.v. Add 2-bit state encodings `SER_IDLE=0, `SER_FIRST=1 and `SER_SECOND=2 to def.v.
- No sub-module. The pair counter is inline.
- The mux itself remains a separate instance at the top level. It is wired directly to Data_in1, Data_in2 and sel.

## Test plan
- Reset then idle: after rst, out_valid=0, sel=0, pair_cnt=0, in_ready=1.
- Single pair: in_data1=16'h1234, in_data2=16'hABCD, in_order=0, out_ready=1.
  - Mux output is 1234 (sel=0, out_last=0), then ABCD (sel=1, out_last=1).
  - pair_cnt=1, and the block returns to IDLE.
- Reversed order with stall: the same pair with in_order=1 and out_ready low for 3 cycles in FIRST.
  - ABCD is held stable for 4 cycles, then 1234 with out_last=1.
- Back-to-back: three pairs offered continuously with out_ready=1.
  - 6 consecutive valid words with no gap; in_ready pulses in each SECOND cycle.
  - pair_cnt=3.
- Reset mid-pair: rst asserted while in SECOND with out_ready=0.
  - Next cycle out_valid=0 and pair_cnt=0. A subsequent pair serializes normally.
- Wrap: CNT_W=2, five pairs completed -> pair_cnt=1.

Source files
------------

// File: rtl/operand_pair_serializer_pkg.sv
// rtl/operand_pair_serializer_pkg.sv - shared width and state encodings for the operand pair serializer
package operand_pair_serializer_pkg;

    localparam int DATA_BITS = 16;

    typedef enum logic [1:0] {
        SER_IDLE   = 2'd0,
        SER_FIRST  = 2'd1,
        SER_SECOND = 2'd2
    } ser_state_e;

endpackage

// File: rtl/operand_pair_serializer.sv
// rtl/operand_pair_serializer.sv - latches an operand pair and steps the 2-to-1 mux select to emit it as two words
module operand_pair_serializer
    import operand_pair_serializer_pkg::*;
#(
    parameter int DATA_W = DATA_BITS,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data1,
    input  logic [DATA_W-1:0] in_data2,
    input  logic              in_order,
    output logic [DATA_W-1:0] Data_in1,
    output logic [DATA_W-1:0] Data_in2,
    output logic              sel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [CNT_W-1:0]  pair_cnt
);

    ser_state_e        state_q;
    ser_state_e        state_d;
    logic              order_q;
    logic              accept;
    logic              pair_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= SER_IDLE;
            Data_in1 <= '0;
            Data_in2 <= '0;
            order_q  <= 1'b0;
            pair_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                Data_in1 <= in_data1;
                Data_in2 <= in_data2;
                order_q  <= in_order;
            end
            if (pair_done) begin
                pair_cnt <= pair_cnt + CNT_W'(1);
            end
        end
    end

    // A new pair may be loaded in the same cycle the second word is handed off,
    // which is what keeps back-to-back pairs free of bubbles.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        sel       = 1'b0;
        pair_done = 1'b0;
        case (state_q)
            SER_IDLE: begin
                in_ready = 1'b1;
            end
            SER_FIRST: begin
                out_valid = 1'b1;
                sel       = order_q;
                if (out_ready) begin
                    state_d = SER_SECOND;
                end
            end
            SER_SECOND: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                sel       = ~order_q;
                in_ready  = out_ready;
                pair_done = out_ready;
                if (out_ready) begin
                    state_d = SER_IDLE;
                end
            end
            default: begin
                state_d = SER_IDLE;
            end
        endcase
        accept = in_valid & in_ready;
        if (accept) begin
            state_d = SER_FIRST;
        end
    end

endmodule

// File: tb/tb_operand_pair_serializer.sv
// tb/tb_operand_pair_serializer.sv - self-checking bench for operand_pair_serializer
module tb_operand_pair_serializer;

    localparam int DW = 16;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data1;
    logic [DW-1:0] in_data2;
    logic          in_order;
    logic [DW-1:0] Data_in1;
    logic [DW-1:0] Data_in2;
    logic          sel;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic [CW-1:0] pair_cnt;

    operand_pair_serializer #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data1  (in_data1),
        .in_data2  (in_data2),
        .in_order  (in_order),
        .Data_in1  (Data_in1),
        .Data_in2  (Data_in2),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .pair_cnt  (pair_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        logic          order;
        logic [DW-1:0] exp_first;
        logic [DW-1:0] exp_second;
    } vec_t;

    typedef struct {
        logic [DW-1:0] word;
        logic          last;
    } exp_t;

    exp_t          exp_q[$];
    int            pop_cycs[$];
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    logic [CW-1:0] cnt_model = '0;
    vec_t          vecs[4];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] mux_out();
        return sel ? Data_in2 : Data_in1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid) begin
                chk("in_ready_decode", {31'd0, in_ready}, {31'd0, out_last & out_ready});
            end
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", {16'd0, mux_out()}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("word", {16'd0, mux_out()}, {16'd0, e.word});
                    chk("out_last", {31'd0, out_last}, {31'd0, e.last});
                    if (e.last) cnt_model = cnt_model + 1'b1;
                    pop_cycs.push_back(cyc);
                end
            end
        end
    endtask

    // Call at posedge+1; returns at posedge+1 after the accepting edge, in_valid left high.
    task automatic send_pair(input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                             input logic order, input logic [DW-1:0] ef, input logic [DW-1:0] es);
        bit ok = 0;
        in_valid = 1'b1;
        in_data1 = d1;
        in_data2 = d2;
        in_order = order;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 0, 1);
        exp_q.push_back('{word: ef, last: 1'b0});
        exp_q.push_back('{word: es, last: 1'b1});
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        cnt_model = '0;
    endtask

    initial begin
        vecs[0] = '{16'h1234, 16'hABCD, 1'b0, 16'h1234, 16'hABCD};
        vecs[1] = '{16'h0000, 16'hFFFF, 1'b1, 16'hFFFF, 16'h0000};
        vecs[2] = '{16'hA5A5, 16'h5A5A, 1'b0, 16'hA5A5, 16'h5A5A};
        vecs[3] = '{16'hFFFF, 16'h0001, 1'b1, 16'h0001, 16'hFFFF};

        rst = 1'b1; in_valid = 1'b0; in_data1 = '0; in_data2 = '0; in_order = 1'b0; out_ready = 1'b1;
        fork monitor(); join_none

        // reset state
        do_reset();
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_sel", {31'd0, sel}, 0);
        chk("rst_out_last", {31'd0, out_last}, 0);
        chk("rst_pair_cnt", {30'd0, pair_cnt}, 0);
        chk("rst_in_ready", {31'd0, in_ready}, 1);
        chk("rst_data1", {16'd0, Data_in1}, 0);
        chk("rst_data2", {16'd0, Data_in2}, 0);
        @(posedge clk); #1;

        // table: one isolated pair each, block must return to idle
        for (int i = 0; i < 4; i++) begin
            send_pair(vecs[i].d1, vecs[i].d2, vecs[i].order, vecs[i].exp_first, vecs[i].exp_second);
            in_valid = 1'b0;
            drain();
            @(negedge clk);
            chk("idle_after_pair", {31'd0, out_valid}, 0);
            chk("pair_cnt_table", {30'd0, pair_cnt}, {30'd0, cnt_model});
            @(posedge clk); #1;
        end

        // reversed order with 3-cycle stall in FIRST
        out_ready = 1'b0;
        send_pair(16'h1234, 16'hABCD, 1'b1, 16'hABCD, 16'h1234);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_valid", {31'd0, out_valid}, 1);
            chk("stall_word", {16'd0, mux_out()}, 32'hABCD);
            chk("stall_last", {31'd0, out_last}, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        drain();
        chk("pair_cnt_stall", {30'd0, pair_cnt}, {30'd0, cnt_model});

        // back-to-back: three pairs, six words with no gap
        do_reset();
        pop_cycs.delete();
        send_pair(16'h1111, 16'h2222, 1'b0, 16'h1111, 16'h2222);
        send_pair(16'h3333, 16'h4444, 1'b1, 16'h4444, 16'h3333);
        send_pair(16'h5555, 16'h6666, 1'b0, 16'h5555, 16'h6666);
        in_valid = 1'b0;
        drain();
        chk("b2b_words", pop_cycs.size(), 6);
        if (pop_cycs.size() == 6) chk("b2b_span", pop_cycs[5] - pop_cycs[0], 5);
        chk("b2b_pair_cnt", {30'd0, pair_cnt}, 3);

        // reset while in SECOND with out_ready low
        do_reset();
        out_ready = 1'b1;
        send_pair(16'hDEAD, 16'hBEEF, 1'b0, 16'hDEAD, 16'hBEEF);
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("pre_rst_second", {31'd0, out_last}, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        cnt_model = '0;
        @(negedge clk);
        chk("midrst_out_valid", {31'd0, out_valid}, 0);
        chk("midrst_pair_cnt", {30'd0, pair_cnt}, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send_pair(16'h0F0F, 16'hF0F0, 1'b1, 16'hF0F0, 16'h0F0F);
        in_valid = 1'b0;
        drain();
        chk("midrst_recover_cnt", {30'd0, pair_cnt}, 1);

        // counter wrap with 2-bit counter
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send_pair(DW'(i), DW'(16'h8000 + i), 1'b0, DW'(i), DW'(16'h8000 + i));
        end
        in_valid = 1'b0;
        drain();
        chk("wrap_pair_cnt", {30'd0, pair_cnt}, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
